apb_master_arbiter: RTL and testbench

//  APB3 master that shares one APB slave port (the APB_module memory) between

---
 rtl/apb_master_arbiter_pkg.sv | 10 +
 rtl/apb_master_arbiter_if.sv | 39 +++
 rtl/apb_master_arbiter_rr_arbiter.sv | 32 +++
 rtl/apb_master_arbiter.sv | 105 ++++++++++
 tb/tb_apb_master_arbiter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_master_arbiter_pkg.sv
// apb_master_arbiter_pkg: shared FSM state type and default bus widths
// Contents:
//   apb_state_t  IDLE -> SETUP -> ACCESS transfer phases
//   ADDR_W_DEF   default PADDR width
//   DATA_W_DEF   default PWDATA/PRDATA width
package apb_master_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
endpackage

// File: rtl/apb_master_arbiter_if.sv
// apb_master_arbiter_if: requester-side handshake plus APB3 bus bundle
// Signals:
//   req_valid/req_write/req_addr/req_wdata  requester inputs (packed per requester)
//   req_ready/rsp_valid                     one-hot accept strobe / completion pulse
//   rsp_rdata/rsp_err                       read data / timeout flag, valid with rsp_valid
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA        APB master outputs
//   PRDATA/PREADY                           APB slave returns
// Modports: master (arbiter view), slave (requesters + APB slave view)
interface apb_master_arbiter_if
  import apb_master_arbiter_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_write;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   rsp_err;
  logic                   PSEL;
  logic                   PENABLE;
  logic                   PWRITE;
  logic [ADDR_W-1:0]      PADDR;
  logic [DATA_W-1:0]      PWDATA;
  logic [DATA_W-1:0]      PRDATA;
  logic                   PREADY;
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first request at or above i_ptr with wrap
// Ports:
//   i_req    request vector
//   i_ptr    highest-priority index (register lives in the parent)
//   i_en     grant enable; no grant when low
//   o_grant  one-hot grant
//   o_idx    index of the granted requester
//   o_valid  a grant was issued
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  input  logic            i_en,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx,
  output logic            o_valid
);
  // Scan from farthest to nearest so the nearest request from i_ptr wins.
  always_comb begin
    o_idx = '0;
    o_valid = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (i_en && i_req[(int'(i_ptr) + k) % NREQ]) begin
        o_valid = 1'b1;
        o_idx = IW'((int'(i_ptr) + k) % NREQ);
      end
    end
    o_grant = o_valid ? NREQ'(1) << o_idx : '0;
  end
endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: APB3 master sharing one slave between NREQ round-robin requesters
// Ports:
//   PCLK     bus clock, rising edge
//   PRESETn  asynchronous active-low reset
//   bus      apb_master_arbiter_if.master: requester handshake, responses and APB bus
// Parameters: NREQ (2..8), ADDR_W, DATA_W, TIMEOUT (>=2 ACCESS cycles before abort)
module apb_master_arbiter
  import apb_master_arbiter_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  apb_master_arbiter_if.master bus
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);
  apb_state_t        r_state;
  apb_state_t        w_next;
  logic [IW-1:0]     r_ptr;
  logic [IW-1:0]     r_gidx;
  logic [CW-1:0]     r_cnt;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic [NREQ-1:0]   r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic [NREQ-1:0]   w_grant;
  logic [IW-1:0]     w_idx;
  logic              w_gvalid;
  logic              w_accept;
  logic              w_done;
  logic              w_abort;
  // Reset is folded into the enable so req_ready is low while PRESETn is held.
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .i_en    ((r_state == IDLE) && PRESETn),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_gvalid)
  );
  assign bus.req_ready = w_grant;
  assign bus.PSEL      = r_psel;
  assign bus.PENABLE   = r_penable;
  assign bus.PWRITE    = r_pwrite;
  assign bus.PADDR     = r_paddr;
  assign bus.PWDATA    = r_pwdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  always_comb begin
    w_accept = (r_state == IDLE) && w_gvalid;
    w_done = (r_state == ACCESS) && bus.PREADY;
    w_abort = (r_state == ACCESS) && !bus.PREADY && (r_cnt == CW'(TIMEOUT - 1));
    w_next = w_accept ? SETUP : (r_state == SETUP) ? ACCESS : (w_done || w_abort) ? IDLE : r_state;
  end
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_gidx <= '0;
      r_cnt <= '0;
      r_psel <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite <= 1'b0;
      r_paddr <= '0;
      r_pwdata <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rsp_valid <= '0;
      if (w_accept) begin
        r_gidx <= w_idx;
        r_ptr <= (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
        r_pwrite <= bus.req_write[w_idx];
        r_paddr <= bus.req_addr[w_idx*ADDR_W +: ADDR_W];
        r_pwdata <= bus.req_wdata[w_idx*DATA_W +: DATA_W];
        r_psel <= 1'b1;
        r_penable <= 1'b0;
      end
      if (r_state == SETUP) begin
        r_penable <= 1'b1;
        r_cnt <= '0;
      end
      if (r_state == ACCESS) r_cnt <= r_cnt + 1'b1;
      // Completion and abort share the response path; only the error flag and data differ.
      if (w_done || w_abort) begin
        r_psel <= 1'b0;
        r_penable <= 1'b0;
        r_rsp_valid <= NREQ'(1) << r_gidx;
        r_rsp_err <= w_abort;
        r_rsp_rdata <= (w_done && !r_pwrite) ? bus.PRDATA : '0;
      end
    end
  end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed and randomized check of apb_master_arbiter against a transfer-level model
module tb_apb_master_arbiter;
  localparam int N = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  apb_master_arbiter_if #(.NREQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
  apb_master_arbiter #(.NREQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .PCLK    (clk),
    .PRESETn (rst_n),
    .bus     (bus)
  );
  logic [DW-1:0] smem [16] = '{default: '0};
  always @(posedge clk) if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE) smem[bus.PADDR[5:2]] <= bus.PWDATA;
  assign bus.PRDATA = smem[bus.PADDR[5:2]];
  int n_checks = 0;
  int n_fail = 0;
  int ph = 0;
  int nacc = 0;
  int m_ptr = 0;
  int m_g = 0;
  logic e_psel = 1'b0;
  logic e_pen = 1'b0;
  logic e_pwrite = 1'b0;
  logic [AW-1:0] e_paddr = '0;
  logic [DW-1:0] e_pwdata = '0;
  logic [DW-1:0] e_rd = '0;
  logic [N-1:0] e_rv = '0;
  logic e_err = 1'b0;
  logic [DW-1:0] mmem [16] = '{default: '0};
  logic [N-1:0] acc = '0;
  logic [N-1:0] outst = '0;
  logic [N-1:0] d_set = '0;
  logic [N-1:0] d_wr = '0;
  logic [AW-1:0] d_addr [N] = '{default: '0};
  logic [DW-1:0] d_data [N] = '{default: '0};
  int reissue [N] = '{default: 0};
  int pr_mode = 1;
  bit rand_en = 1'b0;
  logic rst_drv = 1'b0;
  int grants [$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick_check();
    @(negedge clk);
    chk("PSEL", 64'(bus.PSEL), 64'(e_psel));
    chk("PENABLE", 64'(bus.PENABLE), 64'(e_pen));
    chk("PWRITE", 64'(bus.PWRITE), 64'(e_pwrite));
    chk("PADDR", 64'(bus.PADDR), 64'(e_paddr));
    chk("PWDATA", 64'(bus.PWDATA), 64'(e_pwdata));
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(e_rv));
    if (e_rv != '0) begin
      chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e_rd));
      chk("rsp_err", 64'(bus.rsp_err), 64'(e_err));
    end
  endtask
  task automatic drive();
    rst_n = rst_drv;
    for (int i = 0; i < N; i++) begin
      if (!rst_drv) begin
        outst[i] = 1'b0;
        acc[i] = 1'b0;
      end
      if (bus.rsp_valid[i]) begin
        outst[i] = 1'b0;
        if (reissue[i] > 0) begin
          reissue[i]--;
          d_set[i] = 1'b1;
          d_data[i] = $urandom;
        end
      end
      if (acc[i]) begin
        bus.req_valid[i] = 1'b0;
        outst[i] = 1'b1;
        acc[i] = 1'b0;
      end
      if (d_set[i]) begin
        bus.req_valid[i] = 1'b1;
        bus.req_write[i] = d_wr[i];
        bus.req_addr[i*AW +: AW] = d_addr[i];
        bus.req_wdata[i*DW +: DW] = d_data[i];
        d_set[i] = 1'b0;
      end else if (rand_en && !bus.req_valid[i] && !outst[i] && $urandom_range(0, 3) == 0) begin
        bus.req_valid[i] = 1'b1;
        bus.req_write[i] = 1'($urandom_range(0, 1));
        bus.req_addr[i*AW +: AW] = AW'($urandom_range(0, 15) * 4);
        bus.req_wdata[i*DW +: DW] = $urandom;
      end else if (rand_en && bus.req_valid[i] && $urandom_range(0, 19) == 0) begin
        bus.req_valid[i] = 1'b0;
      end
    end
    bus.PREADY = (pr_mode == 0) ? ($urandom_range(0, 2) != 0) : (pr_mode == 1);
  endtask
  // Transfer-level model: a request is granted by rotation from the pointer when the bus is
  // free, spends one cycle in setup, then access cycles until PREADY or TO access cycles.
  task automatic tick_model();
    int g;
    logic [N-1:0] er;
    #1;
    g = -1;
    if (ph == 0 && rst_n) for (int k = 0; k < N; k++) if (g < 0 && bus.req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    er = (g >= 0) ? N'(1) << g : '0;
    chk("req_ready", 64'(bus.req_ready), 64'(er));
    for (int i = 0; i < N; i++) begin
      acc[i] = bus.req_ready[i] & bus.req_valid[i];
      if (acc[i]) grants.push_back(i);
    end
    e_rv = '0;
    if (!rst_n) begin
      ph = 0;
      m_ptr = 0;
      e_psel = 1'b0;
      e_pen = 1'b0;
      e_pwrite = 1'b0;
      e_paddr = '0;
      e_pwdata = '0;
      e_rd = '0;
      e_err = 1'b0;
    end else if (ph == 0) begin
      if (g >= 0) begin
        m_g = g;
        m_ptr = (g + 1) % N;
        e_pwrite = bus.req_write[g];
        e_paddr = bus.req_addr[g*AW +: AW];
        e_pwdata = bus.req_wdata[g*DW +: DW];
        e_psel = 1'b1;
        e_pen = 1'b0;
        ph = 1;
      end
    end else if (ph == 1) begin
      e_pen = 1'b1;
      nacc = 0;
      ph = 2;
    end else if (bus.PREADY || nacc == TO - 1) begin
      e_err = !bus.PREADY;
      e_rd = (bus.PREADY && !e_pwrite) ? mmem[e_paddr[5:2]] : '0;
      if (bus.PREADY && e_pwrite) mmem[e_paddr[5:2]] = e_pwdata;
      e_psel = 1'b0;
      e_pen = 1'b0;
      e_rv = N'(1) << m_g;
      ph = 0;
    end else begin
      nacc++;
    end
  endtask
  task automatic run_cycle();
    tick_check();
    drive();
    tick_model();
  endtask
  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    d_set[i] = 1'b1;
    d_wr[i] = wr;
    d_addr[i] = a;
    d_data[i] = d;
  endtask
  task automatic wait_rsp(input int i, input int lim, output int n);
    n = 0;
    do begin
      run_cycle();
      n++;
    end while (!bus.rsp_valid[i] && n < lim);
  endtask
  initial begin
    int n;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.PREADY = 1'b0;
    repeat (3) run_cycle();
    chk("reset_rdata", 64'(bus.rsp_rdata), 64'(0));
    chk("reset_err", 64'(bus.rsp_err), 64'(0));
    rst_drv = 1'b1;
    pr_mode = 1;
    run_cycle();
    set_req(0, 1'b1, 32'h10, 32'hDEADBEEF);
    run_cycle();
    chk("t1_ready", 64'(bus.req_ready), 64'(2'b01));
    run_cycle();
    chk("t1_setup_psel", 64'(bus.PSEL), 64'(1));
    chk("t1_setup_penable", 64'(bus.PENABLE), 64'(0));
    chk("t1_pwdata", 64'(bus.PWDATA), 64'(32'hDEADBEEF));
    chk("t1_paddr", 64'(bus.PADDR), 64'(32'h10));
    run_cycle();
    chk("t1_access_penable", 64'(bus.PENABLE), 64'(1));
    run_cycle();
    chk("t1_rsp_valid", 64'(bus.rsp_valid), 64'(2'b01));
    chk("t1_rsp_err", 64'(bus.rsp_err), 64'(0));
    set_req(1, 1'b0, 32'h10, 32'h0);
    run_cycle();
    chk("t2_ready", 64'(bus.req_ready), 64'(2'b10));
    repeat (3) run_cycle();
    chk("t2_rsp_valid", 64'(bus.rsp_valid), 64'(2'b10));
    chk("t2_rdata", 64'(bus.rsp_rdata), 64'(32'hDEADBEEF));
    grants.delete();
    reissue[0] = 3;
    reissue[1] = 3;
    set_req(0, 1'b1, 32'h20, 32'h11111111);
    set_req(1, 1'b0, 32'h24, 32'h0);
    repeat (32) run_cycle();
    chk("t3_grant_count", 64'(grants.size()), 64'(8));
    for (int k = 0; k < grants.size() && k < 8; k++) chk("t3_grant_order", 64'(grants[k]), 64'(k % 2));
    pr_mode = 2;
    set_req(0, 1'b0, 32'h10, 32'h0);
    run_cycle();
    chk("t4_ready", 64'(bus.req_ready), 64'(2'b01));
    run_cycle();
    repeat (3) begin
      run_cycle();
      chk("t4_psel_hold", 64'(bus.PSEL), 64'(1));
      chk("t4_penable_hold", 64'(bus.PENABLE), 64'(1));
      chk("t4_paddr_hold", 64'(bus.PADDR), 64'(32'h10));
      chk("t4_no_rsp", 64'(bus.rsp_valid), 64'(0));
    end
    pr_mode = 1;
    run_cycle();
    chk("t4_last_psel", 64'(bus.PSEL), 64'(1));
    run_cycle();
    chk("t4_rsp_valid", 64'(bus.rsp_valid), 64'(2'b01));
    chk("t4_rdata", 64'(bus.rsp_rdata), 64'(32'hDEADBEEF));
    pr_mode = 2;
    set_req(1, 1'b1, 32'h30, 32'hCAFEF00D);
    set_req(0, 1'b0, 32'h30, 32'h0);
    wait_rsp(1, 40, n);
    chk("t5_abort_latency", 64'(n), 64'(19));
    chk("t5_err", 64'(bus.rsp_err), 64'(1));
    chk("t5_rdata", 64'(bus.rsp_rdata), 64'(0));
    pr_mode = 1;
    wait_rsp(0, 20, n);
    chk("t5_next_latency", 64'(n), 64'(3));
    chk("t5_next_err", 64'(bus.rsp_err), 64'(0));
    chk("t5_next_rdata", 64'(bus.rsp_rdata), 64'(0));
    pr_mode = 2;
    set_req(0, 1'b1, 32'h34, 32'h12345678);
    repeat (4) run_cycle();
    chk("t6_in_access", 64'(bus.PENABLE), 64'(1));
    rst_drv = 1'b0;
    set_req(1, 1'b0, 32'h10, 32'h0);
    run_cycle();
    chk("t6_psel_reset", 64'(bus.PSEL), 64'(0));
    chk("t6_penable_reset", 64'(bus.PENABLE), 64'(0));
    chk("t6_rsp_reset", 64'(bus.rsp_valid), 64'(0));
    set_req(0, 1'b0, 32'h34, 32'h0);
    run_cycle();
    rst_drv = 1'b1;
    pr_mode = 1;
    run_cycle();
    chk("t6_first_grant", 64'(bus.req_ready), 64'(2'b01));
    wait_rsp(0, 20, n);
    chk("t6_dropped_write", 64'(bus.rsp_rdata), 64'(0));
    repeat (8) run_cycle();
    rand_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      pr_mode = (c % 500 >= 460) ? 2 : 0;
      run_cycle();
    end
    rand_en = 1'b0;
    pr_mode = 1;
    repeat (40) run_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
